// File: rtl/usb_rx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// usb_rx_pkg : shared types and line constants for the USB receive front end
// Revision   : 1.0 - initial release
// ----------------------------------------------------------------------------
package usb_rx_pkg;

  typedef enum logic [0:0] {
    S_DATA  = 1'b0,
    S_STUFF = 1'b1
  } rx_destuff_state_e;

  localparam int   USB_STUFF_LEN = 6;
  localparam logic USB_J_LEVEL   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/nrzi_bit_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nrzi_bit_decoder : tracks the previous line level and decodes NRZI
//                    (no transition = 1, transition = 0)
// Revision         : 1.0 - initial release
// ----------------------------------------------------------------------------
module nrzi_bit_decoder
  import usb_rx_pkg::*;
#(
  parameter logic IDLE_LEVEL = USB_J_LEVEL
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_nrzi,
  input  logic i_valid,
  input  logic i_rearm,
  output logic o_bit,
  output logic o_bit_valid
);

  logic r_prev_level;

  // Re-arming wins over a same-cycle sample: the line is assumed idle afterwards.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_prev_level <= IDLE_LEVEL;
    end else if (i_rearm) begin
      r_prev_level <= IDLE_LEVEL;
    end else if (i_valid) begin
      r_prev_level <= i_nrzi;
    end
  end

  assign o_bit       = ~(i_nrzi ^ r_prev_level);
  assign o_bit_valid = i_valid;

endmodule
`default_nettype wire

// File: rtl/nrzi_destuff_deser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nrzi_destuff_deser : NRZI decode, bit de-stuffing and LSB-first deserialiser
// Revision           : 1.0 - initial release
// ----------------------------------------------------------------------------
module nrzi_destuff_deser
  import usb_rx_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   STUFF_LEN  = USB_STUFF_LEN,
  parameter logic IDLE_LEVEL = USB_J_LEVEL
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_nrzi,
  input  logic                       i_valid,
  input  logic                       i_clear,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(WIDTH+1)-1:0] o_nbits,
  output logic                       o_valid,
  output logic                       o_error,
  output logic                       o_stuffed
);

  localparam int c_cnt_w = $clog2(WIDTH+1);
  localparam int c_run_w = $clog2(STUFF_LEN+1);

  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH-1);
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(WIDTH);
  localparam logic [c_run_w-1:0] c_run_last = c_run_w'(STUFF_LEN-1);

  rx_destuff_state_e r_state, w_state_nxt;
  logic [c_run_w-1:0] r_run_cnt, w_run_cnt_nxt;
  logic [c_cnt_w-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [WIDTH-1:0]   r_shift, w_shift_nxt, w_shift_app;
  logic [WIDTH-1:0]   w_data_nxt;
  logic [c_cnt_w-1:0] w_nbits_nxt;
  logic               w_emit, w_error, w_stuffed;
  logic               w_bit, w_bit_valid;

  nrzi_bit_decoder #(
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_decoder (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_nrzi      (i_nrzi),
    .i_valid     (i_valid),
    .i_rearm     (i_clear | i_flush),
    .o_bit       (w_bit),
    .o_bit_valid (w_bit_valid)
  );

  assign w_shift_app = r_shift | ({{(WIDTH-1){1'b0}}, w_bit} << r_bit_cnt);

  always_comb begin
    w_state_nxt   = r_state;
    w_run_cnt_nxt = r_run_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_data_nxt    = o_data;
    w_nbits_nxt   = o_nbits;
    w_emit        = 1'b0;
    w_error       = 1'b0;
    w_stuffed     = 1'b0;

    if (w_bit_valid) begin
      case (r_state)
        S_DATA: begin
          w_shift_nxt   = w_shift_app;
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (w_bit) begin
            w_run_cnt_nxt = r_run_cnt + 1'b1;
            if (r_run_cnt == c_run_last) begin
              w_state_nxt = S_STUFF;
            end
          end else begin
            w_run_cnt_nxt = '0;
          end
          if (r_bit_cnt == c_last_bit) begin
            w_emit        = 1'b1;
            w_data_nxt    = w_shift_app;
            w_nbits_nxt   = c_full_cnt;
            w_bit_cnt_nxt = '0;
            w_shift_nxt   = '0;
          end
        end
        S_STUFF: begin
          w_run_cnt_nxt = '0;
          w_state_nxt   = S_DATA;
          if (w_bit) begin
            w_error       = 1'b1;
            w_bit_cnt_nxt = '0;
            w_shift_nxt   = '0;
          end else begin
            w_stuffed = 1'b1;
          end
        end
        default: w_state_nxt = S_DATA;
      endcase
    end

    // A word completed by the same-cycle bit already emits; never emit twice.
    if (i_flush) begin
      if (!w_emit && (w_bit_cnt_nxt != '0)) begin
        w_emit      = 1'b1;
        w_data_nxt  = w_shift_nxt;
        w_nbits_nxt = w_bit_cnt_nxt;
      end
      w_state_nxt   = S_DATA;
      w_run_cnt_nxt = '0;
      w_bit_cnt_nxt = '0;
      w_shift_nxt   = '0;
    end

    if (i_clear) begin
      w_state_nxt   = S_DATA;
      w_run_cnt_nxt = '0;
      w_bit_cnt_nxt = '0;
      w_shift_nxt   = '0;
      w_data_nxt    = o_data;
      w_nbits_nxt   = o_nbits;
      w_emit        = 1'b0;
      w_error       = 1'b0;
      w_stuffed     = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state   <= S_DATA;
      r_run_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      o_data    <= '0;
      o_nbits   <= '0;
      o_valid   <= 1'b0;
      o_error   <= 1'b0;
      o_stuffed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_run_cnt <= w_run_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      o_data    <= w_data_nxt;
      o_nbits   <= w_nbits_nxt;
      o_valid   <= w_emit;
      o_error   <= w_error;
      o_stuffed <= w_stuffed;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nrzi_destuff_deser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_nrzi_destuff_deser : scoreboard bench for the NRZI de-stuffing deserialiser
// Revision              : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_nrzi_destuff_deser;

  localparam int K_WORD  = 0;
  localparam int K_ERROR = 1;
  localparam int K_STUFF = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic [3:0] nbits;
  } ev_t;

  logic       clk = 1'b0;
  logic       rstn, nrzi, valid, clear, flush;
  logic [7:0] o_data;
  logic [3:0] o_nbits;
  logic       o_valid, o_error, o_stuffed;

  logic       s_valid, s_err, s_stuffed;
  logic [7:0] sync_lv;
  ev_t        exp_q[$];
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  nrzi_destuff_deser dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_nrzi    (nrzi),
    .i_valid   (valid),
    .i_clear   (clear),
    .i_flush   (flush),
    .o_data    (o_data),
    .o_nbits   (o_nbits),
    .o_valid   (o_valid),
    .o_error   (o_error),
    .o_stuffed (o_stuffed)
  );

  // Every output pulse is matched, in order, against the expectation queue.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic pulse;
      pulse = (k == K_WORD) ? o_valid : (k == K_ERROR) ? o_error : o_stuffed;
      if (pulse === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse kind=%0d data=%h nbits=%0d, expected none", k, o_data, o_nbits);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.kind !== k || (k == K_WORD && (o_data !== e.data || o_nbits !== e.nbits))) begin
            failures++;
            $display("FAIL scoreboard got kind=%0d data=%h nbits=%0d, expected kind=%0d data=%h nbits=%0d",
                     k, o_data, o_nbits, e.kind, e.data, e.nbits);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic push(input int kind, input logic [7:0] d, input logic [3:0] n);
    ev_t e;
    e.kind = kind; e.data = d; e.nbits = n;
    exp_q.push_back(e);
  endtask

  // Drive one cycle; snapshot outputs produced by the previous cycle's inputs.
  task automatic step(input logic lv, input logic vl, input logic fl, input logic cl);
    @(negedge clk);
    s_valid   = o_valid;
    s_err     = o_error;
    s_stuffed = o_stuffed;
    nrzi = lv; valid = vl; flush = fl; clear = cl;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rearm();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    drain(2);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 8; i++) step(sync_lv[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic expect_drained(input string name);
    drain(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s pending=%0d, expected 0 outstanding outputs", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; nrzi = 1'b1; valid = 1'b0; clear = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_data, o_nbits, o_valid, o_error, o_stuffed} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs data=%h nbits=%0d v=%b e=%b s=%b, expected all 0",
               o_data, o_nbits, o_valid, o_error, o_stuffed);
    end
    rstn = 1'b1;
  endtask

  task automatic test_sync();
    push(K_WORD, 8'h80, 4'd8);
    send_sync();
    expect_drained("sync");
    checks++;
    if (o_data !== 8'h80 || o_nbits !== 4'd8) begin
      failures++;
      $display("FAIL sync_hold data=%h nbits=%0d, expected 80/8", o_data, o_nbits);
    end
  endtask

  task automatic test_stuffing();
    logic [8:0] lv;
    lv = 9'b000_111111;
    rearm();
    push(K_STUFF, 8'h00, 4'd0);
    push(K_WORD, 8'hFF, 4'd8);
    for (int i = 0; i < 9; i++) begin
      step(lv[i], 1'b1, 1'b0, 1'b0);
      if (i == 7 || i == 8) begin
        checks++;
        if (s_stuffed !== (i == 7)) begin
          failures++;
          $display("FAIL stuffed_timing at sample %0d got %b, expected %b", i + 1, s_stuffed, (i == 7));
        end
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (s_valid !== 1'b1) begin
      failures++;
      $display("FAIL stuff_word_latency o_valid=%b, expected 1 one cycle after 9th sample", s_valid);
    end
    expect_drained("stuffing");
  endtask

  task automatic test_violation();
    rearm();
    push(K_ERROR, 8'h00, 4'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (s_err !== 1'b1) begin
      failures++;
      $display("FAIL error_timing o_error=%b, expected 1 one cycle after 7th sample", s_err);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (s_err !== 1'b0) begin
      failures++;
      $display("FAIL error_width o_error=%b, expected single-cycle pulse", s_err);
    end
    push(K_WORD, 8'h80, 4'd8);
    send_sync();
    expect_drained("violation");
  endtask

  task automatic test_flush_partial();
    rearm();
    push(K_WORD, 8'h02, 4'd3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (s_valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_latency o_valid=%b, expected 1 after flush", s_valid);
    end
    expect_drained("flush_partial");
  endtask

  task automatic test_flush_stuff_state();
    rearm();
    push(K_WORD, 8'h3F, 4'd6);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    expect_drained("flush_in_stuff");
  endtask

  task automatic test_flush_completing();
    rearm();
    push(K_WORD, 8'h80, 4'd8);
    for (int i = 0; i < 8; i++) step(sync_lv[i], 1'b1, (i == 7), 1'b0);
    expect_drained("flush_completing");
  endtask

  task automatic test_clear_priority();
    rearm();
    for (int i = 0; i < 4; i++) step(sync_lv[i], 1'b1, 1'b0, (i == 3));
    push(K_WORD, 8'h80, 4'd8);
    send_sync();
    expect_drained("clear_priority");
  endtask

  task automatic test_reset_midword();
    rearm();
    for (int i = 0; i < 3; i++) step(sync_lv[i], 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b0; valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checks++;
    if ({o_data, o_nbits, o_valid, o_error, o_stuffed} !== 15'd0) begin
      failures++;
      $display("FAIL midword_reset data=%h nbits=%0d v=%b e=%b s=%b, expected all 0",
               o_data, o_nbits, o_valid, o_error, o_stuffed);
    end
    push(K_WORD, 8'h80, 4'd8);
    send_sync();
    expect_drained("reset_midword");
  endtask

  task automatic test_gapped();
    rearm();
    push(K_WORD, 8'h80, 4'd8);
    for (int i = 0; i < 8; i++) begin
      step(sync_lv[i], 1'b1, 1'b0, 1'b0);
      drain($urandom_range(1, 3));
    end
    expect_drained("gapped");
  endtask

  initial begin
    sync_lv = 8'h2A;
    test_reset();
    test_sync();
    test_stuffing();
    test_violation();
    test_flush_partial();
    test_flush_stuff_state();
    test_flush_completing();
    test_clear_priority();
    test_reset_midword();
    test_gapped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nrzi_destuff_deser.md
Name: nrzi_destuff_deser

Overview:
- USB-style receive front end and parametrised successor of the single-bit NRZI decoder.
- Decodes an NRZI serial stream (no transition = 1, transition = 0) and removes stuffed bits after STUFF_LEN consecutive ones.
- Flags stuffing violations and deserialises the recovered bits LSB-first into WIDTH-bit words.
- Sits between the line sampler / clock-recovery stage and the packet parser.

Parameters:
- WIDTH, 8, output word width in bits (>= 2).
- STUFF_LEN, 6, consecutive decoded ones after which one stuffed zero is expected and dropped (>= 1).
- IDLE_LEVEL, 1'b1, line level assumed at reset, i_clear and flush (J state).

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  reset; one clock, synchronous, active-low.
- i_nrzi  input  1  sampled line level.
- i_valid  input  1  i_nrzi holds a new sample this cycle.
- i_clear  input  1  abort: discard partial word; re-arm the level, run count and FSM.
- i_flush  input  1  end of packet: emit any partial word, then re-arm.
- o_data  output  WIDTH  recovered word, LSB = first received bit; unused upper bits are 0.
- o_nbits  output  $clog2(WIDTH+1)  number of valid bits in o_data (WIDTH for full words).
- o_valid  output  1  one-cycle pulse: o_data/o_nbits valid.
- o_error  output  1  one-cycle pulse: stuffing violation.
- o_stuffed  output  1  one-cycle pulse: a stuffed zero was dropped.

Behaviour:
- Reset (i_rstn=0 at clock edge):
  - o_data=0, o_nbits=0, o_valid=0, o_error=0, o_stuffed=0.
  - prev_level=IDLE_LEVEL, run_cnt=0, bit_cnt=0, shift=0, FSM=S_DATA.
- All outputs are registered. Pulses last exactly one cycle; o_data/o_nbits hold their value between pulses.
- Decode: on an i_valid cycle, bit = ~(i_nrzi ^ prev_level), then prev_level <= i_nrzi. prev_level updates on every i_valid cycle, including stuffed and errored bits.
- FSM, advanced only on i_valid cycles:
  - S_DATA, bit=1: append bit; run_cnt++. If run_cnt reaches STUFF_LEN, go to S_STUFF.
  - S_DATA, bit=0: append bit; run_cnt=0.
  - S_STUFF, bit=0: drop the bit; o_stuffed pulses next cycle; run_cnt=0; go to S_DATA.
  - S_STUFF, bit=1: o_error pulses next cycle; partial word discarded (bit_cnt=0, shift=0); run_cnt=0; go to S_DATA. No o_valid is generated from the discarded bits.
- Deserialise: an appended bit is written to shift[bit_cnt], then bit_cnt++.
  - When bit_cnt reaches WIDTH: o_data=shift, o_nbits=WIDTH, o_valid pulses the cycle after the completing i_valid; bit_cnt=0; shift=0.
  - Latency from the last data bit's i_valid to o_valid: 1 cycle.
  - A word may complete on the bit that sets S_STUFF; the following stuff bit belongs to the next word position but is dropped.
- Flush (i_flush=1):
  - The same-cycle i_valid bit, if any, is processed first.
  - Then, if bit_cnt>0: o_data=shift (upper bits 0), o_nbits=bit_cnt, o_valid pulses.
  - If that bit completed a full word, exactly one o_valid with o_nbits=WIDTH is produced.
  - If bit_cnt==0 and no word completes, there is no o_valid.
  - After a flush: prev_level=IDLE_LEVEL, run_cnt=0, bit_cnt=0, FSM=S_DATA.
  - A flush in S_STUFF with no stuff bit received is not an error.
- Clear (i_clear=1):
  - Highest priority after reset: the same-cycle i_valid sample and i_flush are ignored.
  - No o_valid, o_error or o_stuffed from that cycle.
  - State is re-armed as after a flush.
- When i_valid=0 and there is no clear or flush, all state holds.

Decomposition:
- Shared package usb_rx_pkg:
  - state enum rx_destuff_state_e {S_DATA, S_STUFF};
  - constants USB_STUFF_LEN=6 and USB_J_LEVEL=1'b1.
- Sub-module nrzi_bit_decoder: prev_level register plus decode XNOR, emitting a bit/valid pair. It is the natural split.
- Destuff FSM and deserialiser live in the top module.

Test Plan:
- SYNC: reset, then levels 0,1,0,1,0,1,0,0 with i_valid=1 each cycle -> single o_valid, o_data=8'h80, o_nbits=8, no o_error and no o_stuffed.
- Stuffing: from idle, levels 1,1,1,1,1,1,0,0,0 -> o_stuffed pulse one cycle after the 7th sample; o_valid with o_data=8'hFF one cycle after the 9th sample.
- Violation: from idle, eight samples at level 1 -> o_error pulse one cycle after the 7th sample; no o_valid; the next SYNC sequence still yields 8'h80.
- Flush partial: levels 0,0,1 (bits 0,1,0), then i_flush with i_valid=0 -> o_valid, o_data=8'h02, o_nbits=3.
- Flush with a completing bit: assert i_flush together with the 8th bit of a word -> exactly one o_valid, o_nbits=8.
- Clear priority: i_clear with i_valid on the 4th bit of a word, then SYNC -> no output from the cleared bits; o_data=8'h80. Also assert reset mid-word -> all outputs 0 the next cycle.
- Gapped input: SYNC with i_valid=0 gaps of 1–3 cycles between samples -> same 8'h80 result.
